pc_shooter: RTL and testbench
=============================

# pc_shooter

Computer opponent's attack generator for the 5x5 battleship game. When the game FSM grants the PC its turn, the block waits a configurable think delay. It then picks a not-yet-shot cell on the player's board, with a hunt bias toward the neighbours of its last hit. It offers the coordinates to the game FSM over a valid/ack handshake. It is the PC-side counterpart of the player's cursor/confirm attack path and feeds the same board-update logic.

## Interface
- THINK_CYCLES, 4: cycles spent in THINK before searching (≥1).
- SEED, 8'hA5: LFSR reset value (must be non-zero).
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- turn_req  in  1  one-cycle pulse: PC turn starts.
- boardP  in  [2:0] [4:0][4:0]  player board, indexed boardP[y][x], cell_t encoding.
- shot_ack  in  1  game FSM has applied the shot.
- shot_valid  out  1  shot_x/shot_y hold a shot awaiting ack.
- shot_x  out  3  target column 0..4.
- shot_y  out  3  target row 0..4.
- busy  out  1  high in every state except IDLE.
- no_target  out  1  one-cycle pulse: no unshot cell exists.

## Operation
- Cell encoding: EMPTY=0, SHIP=1, MISS=2, HIT=3. A cell is shootable iff its value is EMPTY or SHIP.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every cycle while rst=1; loads SEED when rst=0.
- States: IDLE, THINK, SEEK, ISSUE, RESULT.
- IDLE: turn_req=1 → THINK and load the think counter with THINK_CYCLES-1.
- THINK: counter decrements. At 0, latch start index s = lfsr[4:0], or lfsr[4:0]-25 if it is ≥25. Go to SEEK.
- SEEK, hunt phase (only if hunt_valid): four slots in order N (y-1), S (y+1), W (x-1), E (x+1) around the hunt cell, one slot per cycle.
  - An out-of-bounds slot or an unshootable cell consumes its cycle.
  - The first shootable slot becomes the target → ISSUE.
  - If all four fail, clear hunt_valid and enter the scan phase.
- SEEK, scan phase: test index i (x=i%5, y=i/5) one per cycle, starting at s and wrapping 24→0.
  - The first shootable index becomes the target → ISSUE.
  - After 25 failures: pulse no_target, clear hunt_valid → IDLE.
- ISSUE: shot_valid=1 with stable shot_x/shot_y until a cycle with shot_ack=1. That cycle → RESULT, and shot_valid drops on the next edge.
- RESULT (1 cycle): sample boardP[shot_y][shot_x].
  - HIT: set hunt cell to (shot_x, shot_y) and set hunt_valid.
  - Otherwise: hunt state unchanged.
  - Then → IDLE.
- turn_req outside IDLE is ignored. shot_ack outside ISSUE is ignored.
- Index/coordinate arithmetic is 5-bit unsigned. Bounds checks use the signed neighbour coordinates before indexing, so boardP is never indexed out of range.

## Timing
- Reset (rst=0 at an edge): state IDLE, shot_valid=0, shot_x=0, shot_y=0, busy=0, no_target=0, hunt_valid=0, LFSR=SEED.
- Reset takes priority over every other input in the same cycle, including mid-handshake. shot_valid is low the cycle after.
- Latency from turn_req (edge k) to shot_valid:
  - Best case: k+THINK_CYCLES+2.
  - Worst case: k+THINK_CYCLES+1+4+25 (hunt phase fully fails, then a full scan).
- busy rises the cycle after turn_req and falls on entry to IDLE.
- shot_ack may already be high in the first ISSUE cycle. The handshake then completes in one cycle.
- boardP must be stable from the cycle after ack until RESULT samples it. The game FSM writes the shot result on the ack edge.

## Structure
- battleship_pkg holds:
  - cell_t enum (EMPTY, SHIP, MISS, HIT);
  - BOARD_N=5 and BOARD_CELLS=25;
  - pcs_state_t enum.
- Sub-module lfsr8 (clk, rst, seed, q) is reused by board placement.
- pc_shooter contains the FSM, think counter, scan index, hunt register and the index→(x,y) divide-by-5 logic.

## Test plan
- Single shootable cell: all MISS/HIT except boardP[2][3]=SHIP, THINK_CYCLES=4, turn_req → shot_valid asserted with shot_x=3, shot_y=2 within 4+1+25 cycles. busy high throughout.
- Board fully shot: every cell MISS, turn_req → no_target pulses exactly once, shot_valid never asserts, IDLE afterwards.
- Hunt: after a shot at (2,2) is acked and the board shows HIT there, next turn with (2,1) EMPTY → shot (2,1) exactly THINK_CYCLES+2 cycles after turn_req.
- Hunt exhaustion: hunt cell (0,0) with (0,1) and (1,0) MISS → scan phase taken, hunt_valid cleared, shot is any shootable cell ≠ a MISS cell.
- Handshake hold: shot_ack held low 10 cycles → shot_valid/x/y stable all 10 cycles. Ack → shot_valid low next cycle. turn_req pulses during ISSUE have no effect.
- Reset mid-ISSUE: rst=0 for one edge while shot_valid=1 → all outputs 0 next cycle, LFSR=SEED. A fresh turn_req yields the same shot sequence as after power-up reset.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared types and helpers for the 5x5 battleship game blocks.
package battleship_pkg;

    localparam int BOARD_N     = 5;
    localparam int BOARD_CELLS = 25;

    // Board cell contents; a cell is still a legal target while EMPTY or SHIP.
    typedef enum logic [2:0] {
        EMPTY = 3'd0,
        SHIP  = 3'd1,
        MISS  = 3'd2,
        HIT   = 3'd3
    } cell_t;

    // PC attack generator states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        THINK  = 3'd1,
        SEEK   = 3'd2,
        ISSUE  = 3'd3,
        RESULT = 3'd4
    } pcs_state_t;

    // True when the cell has not been shot yet.
    function automatic logic is_shootable(input logic [2:0] c);
        return (c == EMPTY) || (c == SHIP);
    endfunction

    // Fetch boardP[y][x] by comparison against every legal coordinate, so an
    // out-of-range coordinate reads back as MISS instead of indexing past the array.
    function automatic logic [2:0] cell_at(
        input logic [BOARD_N-1:0][BOARD_N-1:0][2:0] b,
        input logic [2:0]                           x,
        input logic [2:0]                           y
    );
        logic [2:0] c;
        c = MISS;
        for (int yy = 0; yy < BOARD_N; yy++) begin
            for (int xx = 0; xx < BOARD_N; xx++) begin
                if ((3'(yy) == y) && (3'(xx) == x)) begin
                    c = b[yy][xx];
                end
            end
        end
        return c;
    endfunction

    // Fold a 5-bit random value into the 0..24 cell index range.
    function automatic logic [4:0] start_index(input logic [4:0] r);
        return (r >= 5'(BOARD_CELLS)) ? (r - 5'(BOARD_CELLS)) : r;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4); loads seed while rst is low.
module lfsr8
    import battleship_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    // Shift left, feeding back the XOR of tap bits 8,6,5,4 (indices 7,5,4,3).
    always_comb begin
        q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
    end

    // State register with synchronous seed load.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pc_shooter.sv
// Computer opponent attack generator: think delay, hunt-around-last-hit,
// wrapping scan for an unshot cell, then a valid/ack shot handshake.
module pc_shooter
    import battleship_pkg::*;
#(
    parameter int unsigned THINK_CYCLES = 4,
    parameter logic [7:0]  SEED         = 8'hA5
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               turn_req,
    input  logic [BOARD_N-1:0][BOARD_N-1:0][2:0] boardP,
    input  logic                               shot_ack,
    output logic                               shot_valid,
    output logic [2:0]                         shot_x,
    output logic [2:0]                         shot_y,
    output logic                               busy,
    output logic                               no_target
);

    localparam int                CW         = (THINK_CYCLES > 1) ? $clog2(THINK_CYCLES) : 1;
    localparam logic [CW-1:0]     THINK_LOAD = CW'(THINK_CYCLES - 1);
    localparam logic signed [3:0] N_S        = 4'(BOARD_N);

    pcs_state_t    state_q, state_d;
    logic [CW-1:0] think_q, think_d;
    logic [4:0]    idx_q, idx_d;          // current scan index
    logic [4:0]    tries_q, tries_d;      // scan failures so far
    logic          hunt_phase_q, hunt_phase_d;
    logic [1:0]    slot_q, slot_d;        // 0:N 1:S 2:W 3:E
    logic [2:0]    hunt_x_q, hunt_x_d;
    logic [2:0]    hunt_y_q, hunt_y_d;
    logic          hunt_valid_q, hunt_valid_d;
    logic [2:0]    shot_x_q, shot_x_d;
    logic [2:0]    shot_y_q, shot_y_d;
    logic          no_target_q, no_target_d;

    logic [7:0]        lfsr_val;
    logic              lfsr_unused;
    logic [2:0]        scan_x, scan_y;
    logic              scan_ok;
    logic signed [3:0] nb_x, nb_y;
    logic              nb_in, nb_ok;
    logic [2:0]        result_cell;

    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (SEED),
        .q    (lfsr_val)
    );

    // Only the low five LFSR bits pick the start index.
    assign lfsr_unused = ^lfsr_val[7:5];

    // Split the scan index into column/row (divide by 5 via range compare).
    always_comb begin
        scan_x = 3'd0;
        scan_y = 3'd0;
        if (idx_q >= 5'd20) begin
            scan_y = 3'd4;
            scan_x = 3'(idx_q - 5'd20);
        end else if (idx_q >= 5'd15) begin
            scan_y = 3'd3;
            scan_x = 3'(idx_q - 5'd15);
        end else if (idx_q >= 5'd10) begin
            scan_y = 3'd2;
            scan_x = 3'(idx_q - 5'd10);
        end else if (idx_q >= 5'd5) begin
            scan_y = 3'd1;
            scan_x = 3'(idx_q - 5'd5);
        end else begin
            scan_y = 3'd0;
            scan_x = 3'(idx_q);
        end
        scan_ok = is_shootable(cell_at(boardP, scan_x, scan_y));
    end

    // Signed neighbour of the hunt cell for the current slot, bounds-checked
    // before the board lookup.
    always_comb begin
        nb_x = signed'({1'b0, hunt_x_q});
        nb_y = signed'({1'b0, hunt_y_q});
        case (slot_q)
            2'd0:    nb_y = nb_y - 4'sd1;
            2'd1:    nb_y = nb_y + 4'sd1;
            2'd2:    nb_x = nb_x - 4'sd1;
            default: nb_x = nb_x + 4'sd1;
        endcase
        nb_in = (nb_x >= 4'sd0) && (nb_x < N_S) && (nb_y >= 4'sd0) && (nb_y < N_S);
        nb_ok = nb_in && is_shootable(cell_at(boardP, nb_x[2:0], nb_y[2:0]));
    end

    assign result_cell = cell_at(boardP, shot_x_q, shot_y_q);

    // Next-state and datapath updates for the shooter FSM.
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        think_d      = think_q;
        idx_d        = idx_q;
        tries_d      = tries_q;
        hunt_phase_d = hunt_phase_q;
        slot_d       = slot_q;
        hunt_x_d     = hunt_x_q;
        hunt_y_d     = hunt_y_q;
        hunt_valid_d = hunt_valid_q;
        shot_x_d     = shot_x_q;
        shot_y_d     = shot_y_q;
        no_target_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (turn_req) begin
                    think_d = THINK_LOAD;
                    state_d = THINK;
                end
            end
            THINK: begin
                if (think_q == '0) begin
                    idx_d        = start_index(lfsr_val[4:0]);
                    tries_d      = 5'd0;
                    slot_d       = 2'd0;
                    hunt_phase_d = hunt_valid_q;
                    state_d      = SEEK;
                end else begin
                    think_d = think_q - CW'(1);
                end
            end
            SEEK: begin
                if (hunt_phase_q) begin
                    if (nb_ok) begin
                        shot_x_d = nb_x[2:0];
                        shot_y_d = nb_y[2:0];
                        state_d  = ISSUE;
                    end else if (slot_q == 2'd3) begin
                        // All four neighbours spent: fall back to scanning next cycle.
                        hunt_phase_d = 1'b0;
                        hunt_valid_d = 1'b0;
                    end else begin
                        slot_d = slot_q + 2'd1;
                    end
                end else begin
                    if (scan_ok) begin
                        shot_x_d = scan_x;
                        shot_y_d = scan_y;
                        state_d  = ISSUE;
                    end else if (tries_q == 5'(BOARD_CELLS - 1)) begin
                        no_target_d  = 1'b1;
                        hunt_valid_d = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        tries_d = tries_q + 5'd1;
                        idx_d   = (idx_q == 5'(BOARD_CELLS - 1)) ? 5'd0 : idx_q + 5'd1;
                    end
                end
            end
            ISSUE: begin
                if (shot_ack) begin
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (result_cell == HIT) begin
                    hunt_x_d     = shot_x_q;
                    hunt_y_d     = shot_y_q;
                    hunt_valid_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset overrides any handshake in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            think_q      <= '0;
            idx_q        <= 5'd0;
            tries_q      <= 5'd0;
            hunt_phase_q <= 1'b0;
            slot_q       <= 2'd0;
            hunt_x_q     <= 3'd0;
            hunt_y_q     <= 3'd0;
            hunt_valid_q <= 1'b0;
            shot_x_q     <= 3'd0;
            shot_y_q     <= 3'd0;
            no_target_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            think_q      <= think_d;
            idx_q        <= idx_d;
            tries_q      <= tries_d;
            hunt_phase_q <= hunt_phase_d;
            slot_q       <= slot_d;
            hunt_x_q     <= hunt_x_d;
            hunt_y_q     <= hunt_y_d;
            hunt_valid_q <= hunt_valid_d;
            shot_x_q     <= shot_x_d;
            shot_y_q     <= shot_y_d;
            no_target_q  <= no_target_d;
        end
    end

    assign shot_valid = (state_q == ISSUE);
    assign busy       = (state_q != IDLE);
    assign shot_x     = shot_x_q;
    assign shot_y     = shot_y_q;
    assign no_target  = no_target_q;

endmodule

// File: tb/tb_pc_shooter.sv
// Self-checking bench for pc_shooter: directed scenarios plus random boards,
// checked against a cell-level model of the targeting rules.
module tb_pc_shooter;

    localparam int         THINK = 4;
    localparam logic [7:0] SEED  = 8'hA5;
    localparam int         W     = 3;
    localparam logic [2:0] C_EMPTY = 3'd0;
    localparam logic [2:0] C_SHIP  = 3'd1;
    localparam logic [2:0] C_MISS  = 3'd2;
    localparam logic [2:0] C_HIT   = 3'd3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic turn_req = 1'b0;
    logic shot_ack = 1'b0;
    logic [4:0][4:0][2:0] board;
    logic shot_valid, busy, no_target;
    logic [2:0] shot_x, shot_y;

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [7:0] m_lfsr;
    bit m_hv = 1'b0;
    int m_hx = 0, m_hy = 0;

    // Results of the most recent turn
    int last_px, last_py, last_ox, last_oy, last_lat;

    typedef struct {
        bit none;
        bit hunt_dropped;
        int x;
        int y;
        int lat;
    } pred_t;

    pc_shooter #(.THINK_CYCLES(THINK), .SEED(SEED)) dut (
        .clk        (clk),
        .rst        (rst),
        .turn_req   (turn_req),
        .boardP     (board),
        .shot_ack   (shot_ack),
        .shot_valid (shot_valid),
        .shot_x     (shot_x),
        .shot_y     (shot_y),
        .busy       (busy),
        .no_target  (no_target)
    );

    always #5 clk = ~clk;

    // LFSR model: characteristic taps 8,6,5,4 as a parity mask.
    always @(posedge clk) begin
        m_lfsr <= (!rst) ? SEED : {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit shootable(input logic [2:0] v);
        return (v == C_EMPTY) || (v == C_SHIP);
    endfunction

    function automatic int start_of(input logic [7:0] l);
        int v;
        v = int'(l) % 32;
        if (v >= 25) v = v - 25;
        return v;
    endfunction

    task automatic fill(input logic [2:0] v);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                board[y][x] = v;
    endtask

    task automatic fill_random();
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                board[y][x] = 3'($urandom_range(0, 3));
    endtask

    // Expected target and its turn_req-to-output latency in clock edges.
    function automatic pred_t predict(input int s);
        pred_t p;
        int dx[4];
        int dy[4];
        int base;
        dx = '{0, 0, -1, 1};
        dy = '{-1, 1, 0, 0};
        p = '{default: 0};
        base = 0;
        if (m_hv) begin
            for (int k = 0; k < 4; k++) begin
                int nx, ny;
                nx = m_hx + dx[k];
                ny = m_hy + dy[k];
                if (nx >= 0 && nx < 5 && ny >= 0 && ny < 5 && shootable(board[ny][nx])) begin
                    p.x = nx;
                    p.y = ny;
                    p.lat = THINK + 1 + k + 1;
                    return p;
                end
            end
            p.hunt_dropped = 1'b1;
            base = 4;
        end
        for (int j = 0; j < 25; j++) begin
            int i;
            i = (s + j) % 25;
            if (shootable(board[i / 5][i % 5])) begin
                p.x = i % 5;
                p.y = i / 5;
                p.lat = THINK + 1 + base + j + 1;
                return p;
            end
        end
        p.none = 1'b1;
        p.hunt_dropped = 1'b1;
        p.lat = THINK + 1 + base + 25;
        return p;
    endfunction

    // One full PC turn: request, wait for shot/no_target, hold, ack (or reset), result.
    task automatic run_turn(input int ack_wait, input bit poke, input bit rst_in_issue);
        pred_t p;
        bit seen;
        int c;
        logic [2:0] v;
        p = '{default: 0};
        seen = 1'b0;
        c = 0;
        @(negedge clk);
        turn_req = 1'b1;
        while (!seen && c < THINK + 40) begin
            @(negedge clk);
            c++;
            if (c == 1) turn_req = 1'b0;
            if (c == THINK) p = predict(start_of(m_lfsr));
            if (shot_valid || no_target) seen = 1'b1;
            else check("busy_search", busy, 1);
        end
        if (!seen) begin
            check("turn_timeout", seen, 1);
            return;
        end
        if (p.hunt_dropped) m_hv = 1'b0;
        last_lat = c;
        check("latency", c, p.lat);
        check("no_target", no_target, p.none);
        check("shot_valid", shot_valid, !p.none);
        if (p.none) begin
            @(negedge clk);
            check("no_target_single", no_target, 0);
            check("idle_after_none", busy, 0);
            check("no_valid_after_none", shot_valid, 0);
            check("hunt_cleared", dut.hunt_valid_q, 0);
            return;
        end
        last_px = p.x;
        last_py = p.y;
        last_ox = int'(shot_x);
        last_oy = int'(shot_y);
        check("shot_x", shot_x, p.x);
        check("shot_y", shot_y, p.y);
        check("shot_cell_open", shootable(board[shot_y][shot_x]), 1);
        for (int k = 0; k < ack_wait; k++) begin
            turn_req = poke;
            @(negedge clk);
            check("hold_valid", shot_valid, 1);
            check("hold_x", shot_x, p.x);
            check("hold_y", shot_y, p.y);
        end
        turn_req = 1'b0;
        if (rst_in_issue) begin
            rst = 1'b0;
            @(negedge clk);
            check("rst_valid", shot_valid, 0);
            check("rst_x", shot_x, 0);
            check("rst_y", shot_y, 0);
            check("rst_busy", busy, 0);
            check("rst_no_target", no_target, 0);
            check("rst_lfsr", dut.u_lfsr.q, SEED);
            rst = 1'b1;
            m_hv = 1'b0;
            return;
        end
        shot_ack = 1'b1;
        @(negedge clk);
        shot_ack = 1'b0;
        check("valid_drop", shot_valid, 0);
        check("busy_result", busy, 1);
        // Game FSM records the shot outcome on the ack edge.
        v = board[p.y][p.x];
        if (v == C_SHIP) begin
            board[p.y][p.x] = C_HIT;
            m_hv = 1'b1;
            m_hx = p.x;
            m_hy = p.y;
        end else begin
            board[p.y][p.x] = C_MISS;
        end
        @(negedge clk);
        check("busy_idle", busy, 0);
        check("hunt_valid", dut.hunt_valid_q, m_hv);
    endtask

    logic [4:0][4:0][2:0] b0;
    int ref_x, ref_y;

    initial begin
        fill(C_MISS);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", shot_valid, 0);
        check("reset_x", shot_x, 0);
        check("reset_y", shot_y, 0);
        check("reset_busy", busy, 0);
        check("reset_no_target", no_target, 0);
        check("reset_lfsr", dut.u_lfsr.q, SEED);
        check("reset_hunt", dut.hunt_valid_q, 0);
        rst = 1'b1;

        // Reference turn after power-up on a random board.
        fill_random();
        board[4][4] = C_SHIP;
        b0 = board;
        repeat (W) @(negedge clk);
        run_turn(1, 1'b0, 1'b0);
        ref_x = last_px;
        ref_y = last_py;

        // Single shootable cell at (3,2).
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                board[y][x] = ((x + y) % 2 == 0) ? C_MISS : C_HIT;
        board[2][3] = C_SHIP;
        run_turn(0, 1'b0, 1'b0);
        check("single_x", last_ox, 3);
        check("single_y", last_oy, 2);

        // Board fully shot.
        fill(C_MISS);
        run_turn(0, 1'b0, 1'b0);

        // Hunt: hit at (2,2), then (2,1) opens up.
        fill(C_MISS);
        board[2][2] = C_SHIP;
        run_turn(0, 1'b0, 1'b0);
        board[1][2] = C_EMPTY;
        run_turn(0, 1'b0, 1'b0);
        check("hunt_x", last_ox, 2);
        check("hunt_y", last_oy, 1);
        check("hunt_latency", last_lat, THINK + 2);

        // Hunt exhaustion around the corner (0,0).
        fill(C_MISS);
        board[0][0] = C_SHIP;
        run_turn(0, 1'b0, 1'b0);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                board[y][x] = ($urandom_range(0, 1) == 0) ? C_EMPTY : C_MISS;
        board[0][0] = C_HIT;
        board[1][0] = C_MISS;
        board[0][1] = C_MISS;
        board[3][4] = C_EMPTY;
        run_turn(0, 1'b0, 1'b0);
        check("exhaust_lat_floor", (last_lat >= THINK + 6), 1);

        // Long hold with turn_req pokes during ISSUE.
        fill_random();
        board[1][1] = C_EMPTY;
        run_turn(10, 1'b1, 1'b0);

        // Random turns.
        for (int t = 0; t < 12; t++) begin
            fill_random();
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_turn($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset in ISSUE, then the power-up sequence must repeat.
        board = b0;
        run_turn(2, 1'b0, 1'b1);
        board = b0;
        repeat (W) @(negedge clk);
        run_turn(1, 1'b0, 1'b0);
        check("repro_x", last_ox, ref_x);
        check("repro_y", last_oy, ref_y);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
